// File: rtl/opamp_stim_pkg.sv
// Shared types and constants for the opamp PWM stimulus generator.
package opamp_stim_pkg;

   localparam int unsigned CODE_W = 8;
   localparam int unsigned CNT_W  = 8;

   localparam logic [CODE_W-1:0] CODE_MAX = '1;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

   typedef enum logic [1:0] {
      MODE_STATIC = 2'b00,
      MODE_RAMP   = 2'b01,
      MODE_TRI    = 2'b10,
      MODE_OFF    = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Code plus triangle direction after one period-boundary step
   typedef struct packed {
      dir_e              dir;
      logic [CODE_W-1:0] code;
   } step_t;

   // Per-boundary code update for the active mode; triangle bounces at 0 and max
   function automatic step_t mode_step(mode_e mode, logic [CODE_W-1:0] code, dir_e dir);
      step_t s;
      s.code = code;
      s.dir  = dir;
      case (mode)
         MODE_RAMP: s.code = code + CODE_W'(1);
         MODE_TRI: begin
            if (dir == DIR_UP) begin
               if (code == CODE_MAX) begin
                  s.code = code - CODE_W'(1);
                  s.dir  = DIR_DOWN;
               end else begin
                  s.code = code + CODE_W'(1);
               end
            end else begin
               if (code == '0) begin
                  s.code = CODE_W'(1);
                  s.dir  = DIR_UP;
               end else begin
                  s.code = code - CODE_W'(1);
               end
            end
         end
         default: ;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/opamp_stim_sync.sv
// Two-flop synchronizer for the asynchronous load pad, with rising-edge detect.
module opamp_stim_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_c
);

   logic sync1_q;
   logic sync2_q;
   logic prev_q;

   // Metastability chain plus one delayed copy for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= async_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
      end
   end

   // Decoded purely from flops, so it is glitch-free within the cycle
   assign rise_c = sync2_q & ~prev_q;

endmodule

// File: rtl/opamp_pwm_stim.sv
// Opamp stimulus generator: 256-cycle PWM (or first-order sigma-delta when
// OPAMP_STIM_SDM_EN is defined) with static/ramp/triangle/off code sequencing.
// Loads are shadowed and committed only at the period boundary.
module opamp_pwm_stim (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] code_in,
   input  logic [1:0] mode_in,
   input  logic       ld,
   output logic       pwm_out,
   output logic       period_stb,
   output logic [7:0] cur_code,
   output logic       pending
);

   import opamp_stim_pkg::*;

   logic              ld_rise;
   logic              boundary;
   logic              pwm_bit;
   step_t             step;

   logic [CNT_W-1:0]  cnt_q,         cnt_d;
   logic [CODE_W-1:0] cur_code_q,    cur_code_d;
   mode_e             mode_q,        mode_d;
   dir_e              dir_q,         dir_d;
   logic [CODE_W-1:0] shadow_code_q, shadow_code_d;
   mode_e             shadow_mode_q, shadow_mode_d;
   logic              pending_q,     pending_d;
   logic              pwm_q,         pwm_d;

   opamp_stim_sync u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (ld),
      .rise_c  (ld_rise)
   );

   assign boundary = ena & (cnt_q == CNT_MAX);

`ifdef OPAMP_STIM_SDM_EN
   logic [CODE_W-1:0] acc_q, acc_d;
   logic [CODE_W:0]   sdm_sum;

   assign sdm_sum = {1'b0, acc_q} + {1'b0, cur_code_q};
   assign acc_d   = ena ? sdm_sum[CODE_W-1:0] : acc_q;
   assign pwm_bit = sdm_sum[CODE_W];

   // Sigma-delta accumulator; free-running across period boundaries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   assign pwm_bit = (cnt_q < cur_code_q);
`endif

   // Next-state: shadow capture, period counter, boundary commit/step, output bit
   always_comb begin
      cnt_d         = cnt_q;
      cur_code_d    = cur_code_q;
      mode_d        = mode_q;
      dir_d         = dir_q;
      shadow_code_d = shadow_code_q;
      shadow_mode_d = shadow_mode_q;
      pending_d     = pending_q;
      step          = mode_step(mode_q, cur_code_q, dir_q);

      if (ld_rise) begin
         shadow_code_d = code_in;
         shadow_mode_d = mode_e'(mode_in);
         pending_d     = 1'b1;
      end

      if (ena) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // A load detected on the boundary cycle itself is taken through the _d path
      if (boundary) begin
         if (pending_d) begin
            cur_code_d = shadow_code_d;
            mode_d     = shadow_mode_d;
            dir_d      = DIR_UP;
            pending_d  = 1'b0;
         end else begin
            cur_code_d = step.code;
            dir_d      = step.dir;
         end
      end

      pwm_d = ena & (mode_q != MODE_OFF) & pwm_bit;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q         <= '0;
         cur_code_q    <= '0;
         mode_q        <= MODE_STATIC;
         dir_q         <= DIR_UP;
         shadow_code_q <= '0;
         shadow_mode_q <= MODE_STATIC;
         pending_q     <= 1'b0;
         pwm_q         <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         cur_code_q    <= cur_code_d;
         mode_q        <= mode_d;
         dir_q         <= dir_d;
         shadow_code_q <= shadow_code_d;
         shadow_mode_q <= shadow_mode_d;
         pending_q     <= pending_d;
         pwm_q         <= pwm_d;
      end
   end

   assign pwm_out    = pwm_q;
   assign period_stb = boundary;
   assign cur_code   = cur_code_q;
   assign pending    = pending_q;

endmodule

// File: tb/tb_opamp_pwm_stim.sv
// Scoreboard bench for opamp_pwm_stim: per-period expectations are queued by
// the stimulus and checked by a monitor on each period_stb.
module tb_opamp_pwm_stim;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] code_in = 8'd0;
   logic [1:0] mode_in = 2'd0;
   logic       ld = 1'b0;
   logic       pwm_out;
   logic       period_stb;
   logic [7:0] cur_code;
   logic       pending;

   opamp_pwm_stim dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .code_in    (code_in),
      .mode_in    (mode_in),
      .ld         (ld),
      .pwm_out    (pwm_out),
      .period_stb (period_stb),
      .cur_code   (cur_code),
      .pending    (pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int pend;
      bit chk_pwm;
      int pwm;
   } rec_t;

   rec_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   pushed = 0;
   int   closed = 0;
   bit   saw10 = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input int code, input int pend, input bit chk, input int pwm);
      rec_t r;
      r.code = code;
      r.pend = pend;
      r.chk_pwm = chk;
      r.pwm = pwm;
      exp_q.push_back(r);
      pushed++;
   endtask

   // Monitor: cur_code/pending checked at the strobe; high-count of the period
   // closes one sample later (pwm_out lags the counter by one cycle)
   initial begin
      bit   d_stb;
      bit   have_rec;
      int   pwm_cnt;
      rec_t cur_rec;
      d_stb = 1'b0;
      have_rec = 1'b0;
      pwm_cnt = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            d_stb = 1'b0;
            have_rec = 1'b0;
            pwm_cnt = 0;
            continue;
         end
         if (cur_code == 8'd10) saw10 = 1'b1;
         pwm_cnt += int'(pwm_out);
         if (d_stb) begin
            if (have_rec) begin
               if (cur_rec.chk_pwm) check("period_high_count", pwm_cnt, cur_rec.pwm);
               closed++;
               have_rec = 1'b0;
            end
            pwm_cnt = 0;
         end
         if (period_stb && exp_q.size() > 0) begin
            cur_rec = exp_q.pop_front();
            have_rec = 1'b1;
            check("cur_code_at_stb", int'(cur_code), cur_rec.code);
            check("pending_at_stb", int'(pending), cur_rec.pend);
         end
         d_stb = period_stb;
      end
   end

   task automatic wait_stb(input string tag);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_stb && n < 1000);
      if (!period_stb) check({tag, "_stb_timeout"}, int'(period_stb), 1);
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (closed != pushed && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (closed != pushed) check({tag, "_drain_timeout"}, closed, pushed);
   endtask

   task automatic load(input logic [7:0] c, input logic [1:0] m);
      @(negedge clk);
      code_in = c;
      mode_in = m;
      ld = 1'b1;
      repeat (4) @(negedge clk);
      ld = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int frz_bad;
      int alt_bad;
      logic prev;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_pwm_out", int'(pwm_out), 0);
      check("rst_period_stb", int'(period_stb), 0);
      check("rst_cur_code", int'(cur_code), 0);
      check("rst_pending", int'(pending), 0);
      ena = 1'b1;
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Static 64
      wait_stb("t1");
      push(0, 1, 1, 0);
      push(64, 0, 1, 64);
      push(64, 0, 1, 64);
      load(8'd64, 2'b00);
      wait_done("t1");

      // Ramp from 255 wraps to 0
      push(64, 1, 1, 64);
      push(255, 0, 1, 255);
      push(0, 0, 1, 0);
      push(1, 0, 1, 1);
      push(2, 0, 1, 2);
      load(8'd255, 2'b01);
      wait_done("t2");

      // Triangle bounce at the top
      push(3, 1, 1, 3);
      push(253, 0, 1, 253);
      push(254, 0, 1, 254);
      push(255, 0, 1, 255);
      push(254, 0, 1, 254);
      push(253, 0, 1, 253);
      load(8'd253, 2'b10);
      wait_done("t3");

      // Two loads in one period: last wins
      push(252, 1, 1, 252);
      push(200, 0, 1, 200);
      push(200, 0, 1, 200);
      load(8'd10, 2'b00);
      load(8'd200, 2'b00);
      wait_done("t4");
      check("code10_never_applied", int'(saw10), 0);

      // Load edge detected on the cnt==255 cycle
      wait_stb("t5");
      repeat (254) @(negedge clk);
      push(200, 0, 1, 200);
      push(77, 0, 1, 77);
      code_in = 8'd77;
      mode_in = 2'b00;
      ld = 1'b1;
      repeat (4) @(negedge clk);
      ld = 1'b0;
      wait_done("t5");

      // ena low for 40 cycles mid-period, load accepted meanwhile
      wait_stb("t6");
      repeat (100) @(negedge clk);
      ena = 1'b0;
      push(77, 1, 0, 0);
      push(90, 0, 1, 90);
      frz_bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pwm_out !== 1'b0 || period_stb !== 1'b0) frz_bad++;
         if (i == 5) begin
            code_in = 8'd90;
            mode_in = 2'b00;
            ld = 1'b1;
         end
         if (i == 9) ld = 1'b0;
      end
      check("freeze_outputs_low", frz_bad, 0);
      check("freeze_cur_code", int'(cur_code), 77);
      check("freeze_pending", int'(pending), 1);
      ena = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_stb && n < 1000);
      check("freeze_stb_gap", n, 156);
      wait_done("t6");

      // Reset mid-period with a load pending
      load(8'd150, 2'b01);
      repeat (12) @(negedge clk);
      check("pre_reset_pending", int'(pending), 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_pwm_out", int'(pwm_out), 0);
      check("mid_rst_period_stb", int'(period_stb), 0);
      check("mid_rst_cur_code", int'(cur_code), 0);
      check("mid_rst_pending", int'(pending), 0);
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      push(0, 0, 1, 0);
      push(0, 0, 1, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_stb && n < 1000);
      check("first_period_len", n, 256);
      wait_done("t7");

      // Half-scale code
      push(0, 1, 1, 0);
      push(128, 0, 1, 128);
      load(8'd128, 2'b00);
      wait_done("t8");
`ifdef OPAMP_STIM_SDM_EN
      prev = pwm_out;
      alt_bad = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (pwm_out === prev) alt_bad++;
         prev = pwm_out;
      end
      check("sdm_alternation", alt_bad, 0);
`else
      prev = 1'b0;
      alt_bad = 0;
`endif

      // Off mode: counter and strobe keep running, output held low
      push(128, 1, 1, 128);
      push(100, 0, 1, 0);
      push(100, 0, 1, 0);
      load(8'd100, 2'b11);
      wait_done("t9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
